// File: rtl/row_accumulator.sv
// row_accumulator
//
// Read end of the per-channel product FIFOs in the sparse matrix-vector
// datapath. Each channel pulls a row length from its length FIFO and then
// sums that many signed products into a per-channel accumulator. Finished
// row sums from all channels are merged by a round-robin arbiter into a
// single one-entry output register with a valid/ready handshake.
//
// Ports
//   clk              single clock, everything on the rising edge
//   rst              synchronous active-high reset
//   mult             product FIFO dout, channel i at [i*val_bits*2 +: val_bits*2]
//   mult_fifo_empty  product FIFO empty flags, one per channel
//   mult_fifo_read   product FIFO read enables, one per channel
//   len              row-length FIFO dout, channel i at [i*len_bits +: len_bits]
//   len_fifo_empty   length FIFO empty flags, one per channel
//   len_fifo_read    length FIFO read enables, one per channel
//   sum              signed row sum
//   sum_channel      channel that produced sum
//   sum_valid        sum/sum_channel hold a result
//   sum_ready        downstream accepts the result this cycle
//
// Both FIFO types are standard (non fall-through): dout is valid in the
// cycle after the read enable was high.

module row_accumulator #(
  parameter int channel_num = 4,
  parameter int val_bits    = 16,
  parameter int len_bits    = 16,
  parameter int acc_bits    = 40,
  parameter int ch_bits     = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [val_bits*2*channel_num-1:0] mult,
  input  logic [channel_num-1:0]            mult_fifo_empty,
  output logic [channel_num-1:0]            mult_fifo_read,
  input  logic [len_bits*channel_num-1:0]   len,
  input  logic [channel_num-1:0]            len_fifo_empty,
  output logic [channel_num-1:0]            len_fifo_read,
  output logic [acc_bits-1:0]               sum,
  output logic [ch_bits-1:0]                sum_channel,
  output logic                              sum_valid,
  input  logic                              sum_ready
);

  localparam int prod_bits = val_bits * 2;

  typedef enum logic [1:0] {
    LOAD_LEN,
    WAIT_LEN,
    ACC,
    DONE
  } ch_state_t;

  logic [channel_num-1:0] done_req;
  logic [channel_num-1:0] grant;
  logic [acc_bits-1:0]    acc_arr [channel_num];
  logic                   out_free;
  logic                   grant_found;
  logic [ch_bits-1:0]     grant_idx;
  logic [ch_bits-1:0]     rr_ptr;
  logic [ch_bits-1:0]     scan_idx;

  // The output entry can take a new result when it is empty or when its
  // current result leaves in this same cycle, so back-to-back results
  // flow without a bubble.
  assign out_free = !sum_valid || sum_ready;

  for (genvar i = 0; i < channel_num; i++) begin : g_ch
    ch_state_t             state_q;
    ch_state_t             state_d;
    logic [len_bits-1:0]   len_q;
    logic [len_bits-1:0]   issued_q;
    logic [len_bits-1:0]   received_q;
    logic [len_bits-1:0]   received_inc;
    logic [acc_bits-1:0]   acc_q;
    logic                  rd_pend_q;
    logic                  mult_rd;
    logic                  len_rd;
    logic [prod_bits-1:0]  product;
    logic [len_bits-1:0]   len_in;

    assign product = mult[i*prod_bits +: prod_bits];
    assign len_in  = len[i*len_bits +: len_bits];

    // A product read last cycle lands on dout now; counting it here lets
    // the final add and the move to DONE happen in the same cycle.
    assign received_inc = received_q + len_bits'(rd_pend_q);

    // Next state and read enables. Reads are forced low while rst is high
    // so nothing is pulled from the FIFOs during the reset cycle.
    always_comb begin
      state_d = state_q;
      mult_rd = 1'b0;
      len_rd  = 1'b0;
      case (state_q)
        LOAD_LEN: begin
          if (!len_fifo_empty[i]) begin
            len_rd  = 1'b1;
            state_d = WAIT_LEN;
          end
        end
        WAIT_LEN: begin
          state_d = (len_in == '0) ? DONE : ACC;
        end
        ACC: begin
          if (!mult_fifo_empty[i] && (issued_q < len_q)) begin
            mult_rd = 1'b1;
          end
          if (received_inc == len_q) begin
            state_d = DONE;
          end
        end
        DONE: begin
          if (grant[i]) begin
            state_d = LOAD_LEN;
          end
        end
        default: state_d = LOAD_LEN;
      endcase
      if (rst) begin
        mult_rd = 1'b0;
        len_rd  = 1'b0;
      end
    end

    // State register plus the row counters and accumulator. Entering a
    // row clears everything, so a reset or an earlier row leaves no residue.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q    <= LOAD_LEN;
        len_q      <= '0;
        issued_q   <= '0;
        received_q <= '0;
        acc_q      <= '0;
        rd_pend_q  <= 1'b0;
      end else begin
        state_q   <= state_d;
        rd_pend_q <= mult_rd;
        if (state_q == WAIT_LEN) begin
          len_q      <= len_in;
          issued_q   <= '0;
          received_q <= '0;
          acc_q      <= '0;
        end else begin
          if (mult_rd) begin
            issued_q <= issued_q + 1'b1;
          end
          if (rd_pend_q) begin
            acc_q      <= acc_q + acc_bits'($signed(product));
            received_q <= received_inc;
          end
        end
      end
    end

    assign mult_fifo_read[i] = mult_rd;
    assign len_fifo_read[i]  = len_rd;
    assign done_req[i]       = (state_q == DONE);
    assign acc_arr[i]        = acc_q;
  end

  // Round-robin pick: scan channels starting at rr_ptr and grant the first
  // one sitting in DONE, but only when the output entry can take it.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int off = 0; off < channel_num; off++) begin
      scan_idx = ch_bits'((int'(rr_ptr) + off) % channel_num);
      if (out_free && !grant_found && done_req[scan_idx]) begin
        grant_found     = 1'b1;
        grant_idx       = scan_idx;
        grant[scan_idx] = 1'b1;
      end
    end
  end

  // Output entry and arbiter pointer. Without a grant the entry only
  // drains; sum and sum_channel are left untouched so they stay stable
  // while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum         <= '0;
      sum_channel <= '0;
      sum_valid   <= 1'b0;
      rr_ptr      <= '0;
    end else if (grant_found) begin
      sum         <= acc_arr[grant_idx];
      sum_channel <= grant_idx;
      sum_valid   <= 1'b1;
      rr_ptr      <= (grant_idx == ch_bits'(channel_num - 1)) ? '0 : grant_idx + 1'b1;
    end else if (sum_ready) begin
      sum_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_row_accumulator.sv
// tb_row_accumulator
//
// Drives row_accumulator from behavioural standard-mode FIFO models (one
// product FIFO and one length FIFO per channel). Each row handed to the
// FIFOs also pushes its expected {channel, sum} onto a scoreboard, which a
// monitor pops whenever a result is accepted.

module tb_row_accumulator;

  localparam int channel_num = 4;
  localparam int val_bits    = 16;
  localparam int len_bits    = 16;
  localparam int acc_bits    = 40;
  localparam int ch_bits     = 2;
  localparam int prod_bits   = val_bits * 2;

  logic                              clk = 1'b0;
  logic                              rst;
  logic [prod_bits*channel_num-1:0]  mult;
  logic [channel_num-1:0]            mult_fifo_empty = '1;
  logic [channel_num-1:0]            mult_fifo_read;
  logic [len_bits*channel_num-1:0]   len;
  logic [channel_num-1:0]            len_fifo_empty = '1;
  logic [channel_num-1:0]            len_fifo_read;
  logic [acc_bits-1:0]               sum;
  logic [ch_bits-1:0]                sum_channel;
  logic                              sum_valid;
  logic                              sum_ready;

  row_accumulator #(
    .channel_num(channel_num),
    .val_bits   (val_bits),
    .len_bits   (len_bits),
    .acc_bits   (acc_bits),
    .ch_bits    (ch_bits)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mult           (mult),
    .mult_fifo_empty(mult_fifo_empty),
    .mult_fifo_read (mult_fifo_read),
    .len            (len),
    .len_fifo_empty (len_fifo_empty),
    .len_fifo_read  (len_fifo_read),
    .sum            (sum),
    .sum_channel    (sum_channel),
    .sum_valid      (sum_valid),
    .sum_ready      (sum_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mult_reads [channel_num];
  int len_reads  [channel_num];

  logic [prod_bits-1:0]       mult_dout  [channel_num];
  logic [len_bits-1:0]        len_dout   [channel_num];
  logic [prod_bits-1:0]       mult_q     [channel_num][$];
  logic [len_bits-1:0]        len_q      [channel_num][$];
  logic [prod_bits-1:0]       prod_stage [channel_num][$];
  logic [len_bits-1:0]        len_stage  [channel_num][$];
  logic [ch_bits+acc_bits-1:0] sb [$];
  logic signed [prod_bits-1:0] pbuf [0:31];

  initial begin
    for (int c = 0; c < channel_num; c++) begin
      mult_reads[c] = 0;
      len_reads[c]  = 0;
      mult_dout[c]  = '0;
      len_dout[c]   = '0;
    end
  end

  always_comb begin
    mult = '0;
    len  = '0;
    for (int c = 0; c < channel_num; c++) begin
      mult[c*prod_bits +: prod_bits] = mult_dout[c];
      len[c*len_bits +: len_bits]    = len_dout[c];
    end
  end

  always @(posedge clk) cyc++;

  // Standard-mode FIFO models: a read enable seen at the edge puts the head
  // on dout for the next cycle; staged writes become visible after the edge.
  always @(posedge clk) begin
    for (int c = 0; c < channel_num; c++) begin
      if (rst) begin
        mult_q[c].delete();
        len_q[c].delete();
        prod_stage[c].delete();
        len_stage[c].delete();
        mult_dout[c]       <= '0;
        len_dout[c]        <= '0;
        mult_fifo_empty[c] <= 1'b1;
        len_fifo_empty[c]  <= 1'b1;
      end else begin
        if (mult_fifo_read[c] && mult_q[c].size() > 0) mult_dout[c] <= mult_q[c].pop_front();
        if (len_fifo_read[c] && len_q[c].size() > 0) len_dout[c] <= len_q[c].pop_front();
        while (prod_stage[c].size() > 0) mult_q[c].push_back(prod_stage[c].pop_front());
        while (len_stage[c].size() > 0) len_q[c].push_back(len_stage[c].pop_front());
        mult_fifo_empty[c] <= (mult_q[c].size() == 0);
        len_fifo_empty[c]  <= (len_q[c].size() == 0);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Monitor: read-while-empty guard, read pulse counters, scoreboard pops.
  always @(negedge clk) begin
    logic [ch_bits+acc_bits-1:0] exp_entry;
    if (!rst) begin
      for (int c = 0; c < channel_num; c++) begin
        checkOutput("mult_read_while_empty", mult_fifo_read[c] & mult_fifo_empty[c], 0);
        checkOutput("len_read_while_empty", len_fifo_read[c] & len_fifo_empty[c], 0);
        if (mult_fifo_read[c]) mult_reads[c]++;
        if (len_fifo_read[c]) len_reads[c]++;
      end
      if (sum_valid && sum_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_result", 1, 0);
        end else begin
          exp_entry = sb.pop_front();
          checkOutput("sum", sum, exp_entry[acc_bits-1:0]);
          checkOutput("sum_channel", sum_channel, exp_entry[ch_bits+acc_bits-1:acc_bits]);
        end
      end
    end
  end

  // Stages a row: its length plus the first now_count products of pbuf.
  // The expected sum is modelled over all row_len entries of pbuf.
  task automatic applyStimulus(input int ch, input int row_len, input int now_count, input bit expect_result);
    logic [acc_bits-1:0] model;
    model = '0;
    len_stage[ch].push_back(len_bits'(row_len));
    for (int k = 0; k < row_len; k++) begin
      model = model + acc_bits'(pbuf[k]);
      if (k < now_count) prod_stage[ch].push_back(pbuf[k]);
    end
    if (expect_result) sb.push_back({ch_bits'(ch), model});
  endtask

  task automatic waitLenRead(input int ch, output int t);
    int n = 0;
    while (!len_fifo_read[ch] && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("len_read_timeout", n < 50, 1);
    t = cyc;
  endtask

  task automatic waitValid(output int t);
    int n = 0;
    while (!sum_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("valid_timeout", n < 100, 1);
    t = cyc;
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((sb.size() != 0 || sum_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_timeout", n < 300, 1);
  endtask

  task automatic checkBurst(input string tag, input int first);
    int n = 0;
    while (!sum_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_timeout"}, n < 50, 1);
    for (int k = 0; k < channel_num; k++) begin
      checkOutput({tag, "_valid"}, sum_valid, 1);
      checkOutput({tag, "_chan"}, sum_channel, (first + k) % channel_num);
      @(negedge clk);
    end
  endtask

  initial begin
    int t0, t1, r0, r1;
    rst = 1'b1;
    sum_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_sum_valid", sum_valid, 0);
    checkOutput("rst_sum", sum, 0);
    checkOutput("rst_sum_channel", sum_channel, 0);
    checkOutput("rst_mult_read", mult_fifo_read, 0);
    checkOutput("rst_len_read", len_fifo_read, 0);
    rst = 1'b0;
    @(negedge clk);

    // Channel 0, three back-to-back products.
    $display("[TB] basic row of three on channel 0");
    pbuf[0] = 6; pbuf[1] = -4; pbuf[2] = 10;
    r0 = mult_reads[0];
    applyStimulus(0, 3, 3, 1);
    waitLenRead(0, t0);
    waitValid(t1);
    checkOutput("latency_len3", t1 - t0, 7);
    waitIdle();
    checkOutput("reads_len3", mult_reads[0] - r0, 3);

    // Zero-length row on channel 2.
    $display("[TB] zero-length row on channel 2");
    r0 = mult_reads[2];
    applyStimulus(2, 0, 0, 1);
    waitLenRead(2, t0);
    waitValid(t1);
    checkOutput("latency_len0", t1 - t0, 3);
    waitIdle();
    checkOutput("reads_len0", mult_reads[2] - r0, 0);

    // Round-robin from a fresh pointer, then after a grant to channel 1.
    $display("[TB] round-robin contention");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < channel_num; c++) begin
      pbuf[0] = c + 1;
      applyStimulus(c, 1, 1, 1);
    end
    checkBurst("rr_first", 0);
    waitIdle();
    pbuf[0] = 5;
    applyStimulus(1, 1, 1, 1);
    waitIdle();
    for (int k = 0; k < channel_num; k++) begin
      pbuf[0] = ((k + 2) % channel_num) + 1;
      applyStimulus((k + 2) % channel_num, 1, 1, 1);
    end
    checkBurst("rr_second", 2);
    waitIdle();

    // Output stalled: result held, a finished channel blocks its next row.
    $display("[TB] downstream stall");
    sum_ready = 1'b0;
    pbuf[0] = 7; pbuf[1] = 8;
    applyStimulus(0, 2, 2, 1);
    waitValid(t1);
    r0 = len_reads[1];
    r1 = mult_reads[1];
    pbuf[0] = 100;
    applyStimulus(1, 1, 1, 1);
    pbuf[0] = 200;
    applyStimulus(1, 1, 1, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("stall_valid", sum_valid, 1);
      checkOutput("stall_sum", sum, 15);
      checkOutput("stall_chan", sum_channel, 0);
    end
    checkOutput("stall_len_reads", len_reads[1] - r0, 1);
    checkOutput("stall_mult_reads", mult_reads[1] - r1, 1);
    sum_ready = 1'b1;
    waitIdle();

    // Product FIFO runs dry after two of five products.
    $display("[TB] starved product FIFO");
    pbuf[0] = 3; pbuf[1] = -7; pbuf[2] = 11; pbuf[3] = 20; pbuf[4] = -1;
    r0 = mult_reads[3];
    applyStimulus(3, 5, 2, 1);
    repeat (10) @(negedge clk);
    checkOutput("starve_valid", sum_valid, 0);
    checkOutput("starve_reads", mult_reads[3] - r0, 2);
    for (int k = 2; k < 5; k++) prod_stage[3].push_back(pbuf[k]);
    waitIdle();
    checkOutput("starve_total_reads", mult_reads[3] - r0, 5);

    // Sixteen maximum positive products into a 40-bit accumulator.
    $display("[TB] large accumulation");
    for (int k = 0; k < 16; k++) pbuf[k] = 32'h7FFF_FFFF;
    sb.push_back({ch_bits'(0), 40'h07_FFFF_FFF0});
    applyStimulus(0, 16, 16, 0);
    waitIdle();

    // Reset mid-row with a result pending and a partial sum in flight.
    $display("[TB] reset mid-row");
    sum_ready = 1'b0;
    pbuf[0] = 9;
    applyStimulus(1, 1, 1, 0);
    pbuf[0] = 1000; pbuf[1] = 1000;
    applyStimulus(0, 4, 2, 0);
    repeat (10) @(negedge clk);
    checkOutput("pre_rst_valid", sum_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_valid", sum_valid, 0);
    checkOutput("mid_rst_sum", sum, 0);
    checkOutput("mid_rst_chan", sum_channel, 0);
    checkOutput("mid_rst_mult_read", mult_fifo_read, 0);
    checkOutput("mid_rst_len_read", len_fifo_read, 0);
    rst = 1'b0;
    sb.delete();
    sum_ready = 1'b1;
    pbuf[0] = 5; pbuf[1] = 6;
    applyStimulus(0, 2, 2, 1);
    waitIdle();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
